load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store unit between execute and the register file write port.
//  - Accepts one memory op per handshake from execute.
//  - Drives a word-addressed data-memory bus with byte strobes.
//  - Aligns and extends load data.
//  - Issues a single-cycle register-file write (regw_addr/write_data/write_ena).
//  - One op in flight; execute stalls on req_ready=0.
// PARAMETERS
//  TIMEOUT    255  max cycles waiting for mem_rsp_valid in RESP; 0 = no timeout
//  TIMEOUT_W  8    width of timeout counter; must hold TIMEOUT
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  req_valid      in   1   execute presents an op
//  req_ready      out  1   unit idle, op accepted when req_valid&&req_ready
//  req_is_store   in   1   1=store, 0=load
//  req_funct3     in   3   RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  req_addr       in   32  effective byte address
//  req_wdata      in   32  store data (rs2)
//  req_rd         in   5   load destination register
//  mem_req_valid  out  1   memory request pending
//  mem_req_ready  in   1   memory accepts request
//  mem_addr       out  32  word address ({addr[31:2],2'b00})
//  mem_we         out  1   1=write
//  mem_wstrb      out  4   byte-lane enables
//  mem_wdata      out  32  lane-replicated store data
//  mem_rsp_valid  in   1   load data valid
//  mem_rdata      in   32  load word
//  regw_addr      out  5   register-file write address
//  write_data     out  32  register-file write data
//  write_ena      out  1   register-file write strobe, one cycle
//  done           out  1   op completed (one-cycle pulse)
//  err            out  1   op aborted: bad funct3, timeout, misalign (one-cycle pulse)
// BEHAVIOUR
//  States: IDLE -> REQ -> (store) IDLE | (load) RESP -> WB -> IDLE.
//  Reset:
//  - state=IDLE; all outputs 0 except req_ready=1.
//  - Async assert mid-op aborts the op; no write, no done.
//  Request capture and dispatch:
//  - IDLE: req_ready=1; on handshake, latch all req_* fields.
//  - Valid op: -> REQ next cycle.
//  - Invalid funct3 (load 3/6/7, store >2): err pulse next cycle, no bus access, stay IDLE.
//  - REQ: mem_req_valid=1; mem_addr/mem_we/mem_wstrb/mem_wdata held stable until mem_req_ready.
//  Store completion:
//  - On handshake, done pulses the next cycle in IDLE.
//  - Earliest completion is 2 cycles after acceptance.
//  - Lane rules, off=addr[1:0]:
//    - SB: wstrb=4'b0001<<off, wdata={4{wdata[7:0]}}
//    - SH: wstrb=4'b0011<<{off[1],1'b0}, wdata={2{wdata[15:0]}}
//    - SW: wstrb=4'b1111, wdata=wdata
//  Load response (RESP):
//  - Timeout counter starts at 0 on entry and increments each cycle without mem_rsp_valid.
//  - On mem_rsp_valid: capture (mem_rdata >> 8*off), sign- (LB/LH) or zero- (LBU/LHU) extend; LW unshifted -> WB.
//  - Counter == TIMEOUT (TIMEOUT!=0): err pulse next cycle, -> IDLE, no write.
//  - mem_rsp_valid outside RESP is ignored.
//  Writeback (WB):
//  - write_ena=1 for exactly one cycle with regw_addr=rd and write_data=extended value; done=1 same cycle; -> IDLE.
//  - rd==0: write_ena stays 0, done still pulses.
//  Latency: load with zero-wait memory (ready and rsp the cycle after request) completes 4 cycles after acceptance.
//  done and err are never both 1; req_ready=0 in every state but IDLE.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//  - Misaligned halfword (addr[0]) or word (addr[1:0]!=0) ops are accepted, then get an err pulse next cycle.
//  - No bus access and no write.
//  MISALIGN_TRAP_EN undefined:
//  - Offending low bits are ignored: halfword uses addr[1] only, word uses offset 0.
//  - The op proceeds normally with no err.
// TESTING
//  1 LB addr 0x1003, rdata 0x80FFFF00, rd=5 -> mem_addr 0x1000, write_data 0xFFFFFF80, regw_addr 5, write_ena 1 cycle.
//  2 SH addr 0x2002, wdata 0x0000BEEF -> mem_addr 0x2000, wstrb 4'b1100, mem_wdata 0xBEEFBEEF, mem_we 1, done, no write_ena.
//  3 LW rd=0, rdata 0x12345678 -> done pulses, write_ena stays 0.
//  4 TIMEOUT=4, LHU, mem_rsp_valid never asserted -> err 1 cycle after counter hits 4, back in IDLE, req_ready=1.
//  5 LW addr 0x1001: with MISALIGN_TRAP_EN -> err, mem_req_valid never 1; without -> mem_addr 0x1000, normal write.
//  6 rst pulse while in RESP, then mem_rsp_valid -> no write_ena, no done, req_ready=1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Execute-request, data-memory and register-file-write signals of the load/store unit.
// The slave modport is the unit's view; master is the surrounding pipeline/memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic [4:0]  regw_addr;
  logic [31:0] write_data;
  logic        write_ena;
  logic        done;
  logic        err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
           regw_addr, write_data, write_ena, done, err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
           regw_addr, write_data, write_ena, done, err
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: one op in flight, word-addressed memory bus with strobes.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word ops abort with err instead of truncating offset.
module load_store_unit #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

  state_t                 state;
  logic                   is_store_q;
  logic [2:0]             funct3_q;
  logic [1:0]             off_q;
  logic [4:0]             rd_q;
  logic [31:0]            result_q;
  logic [TIMEOUT_W-1:0]   tcount;

  logic                   req_bad;
  logic [3:0]             strb_next;
  logic [31:0]            wdata_next;
  logic [1:0]             off_eff;
  logic [31:0]            shifted;
  logic [31:0]            load_value;

  // Decode of the incoming request: legality, byte strobes and lane-replicated store data.
  always_comb begin
    req_bad    = 1'b0;
    strb_next  = 4'b1111;
    wdata_next = bus.req_wdata;
    if (bus.req_is_store)
      req_bad = (bus.req_funct3 > 3'd2);
    else
      req_bad = !(bus.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
    if (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0])
      req_bad = 1'b1;
    if (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0)
      req_bad = 1'b1;
`endif
    case (bus.req_funct3[1:0])
      2'd0: begin
        strb_next  = 4'b0001 << bus.req_addr[1:0];
        wdata_next = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        strb_next  = 4'b0011 << {bus.req_addr[1], 1'b0};
        wdata_next = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        strb_next  = 4'b1111;
        wdata_next = bus.req_wdata;
      end
    endcase
  end

  // Load alignment: halfwords honour only addr[1], words are never shifted.
  always_comb begin
    off_eff = off_q;
    if (funct3_q[1:0] == 2'd1)
      off_eff = {off_q[1], 1'b0};
    else if (funct3_q[1:0] == 2'd2)
      off_eff = 2'd0;
    shifted = bus.mem_rdata >> {off_eff, 3'b000};
    case (funct3_q)
      3'd0:    load_value = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_value = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_value = {24'd0, shifted[7:0]};
      3'd5:    load_value = {16'd0, shifted[15:0]};
      default: load_value = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      is_store_q        <= 1'b0;
      funct3_q          <= 3'd0;
      off_q             <= 2'd0;
      rd_q              <= 5'd0;
      result_q          <= 32'd0;
      tcount            <= '0;
      bus.req_ready     <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= 32'd0;
      bus.mem_we        <= 1'b0;
      bus.mem_wstrb     <= 4'd0;
      bus.mem_wdata     <= 32'd0;
      bus.regw_addr     <= 5'd0;
      bus.write_data    <= 32'd0;
      bus.write_ena     <= 1'b0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.write_ena <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            is_store_q <= bus.req_is_store;
            funct3_q   <= bus.req_funct3;
            off_q      <= bus.req_addr[1:0];
            rd_q       <= bus.req_rd;
            if (req_bad) begin
              bus.err <= 1'b1;
            end else begin
              state             <= REQ;
              bus.req_ready     <= 1'b0;
              bus.mem_req_valid <= 1'b1;
              bus.mem_addr      <= {bus.req_addr[31:2], 2'b00};
              bus.mem_we        <= bus.req_is_store;
              bus.mem_wstrb     <= bus.req_is_store ? strb_next : 4'd0;
              bus.mem_wdata     <= bus.req_is_store ? wdata_next : 32'd0;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_wstrb     <= 4'd0;
            if (is_store_q) begin
              state         <= IDLE;
              bus.req_ready <= 1'b1;
              bus.done      <= 1'b1;
            end else begin
              state  <= RESP;
              tcount <= '0;
            end
          end
        end
        RESP: begin
          // A response arriving on the timeout cycle still wins over the abort.
          if (bus.mem_rsp_valid) begin
            result_q <= load_value;
            state    <= WB;
          end else if (TIMEOUT != 0 && tcount == TIMEOUT_W'(TIMEOUT)) begin
            bus.err       <= 1'b1;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        WB: begin
          bus.write_ena  <= (rd_q != 5'd0);
          bus.regw_addr  <= rd_q;
          bus.write_data <= result_q;
          bus.done       <= 1'b1;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=4); adapts to MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic is_store, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd);
    checkOutput("req_ready_before_op", {31'd0, bus.req_ready}, 32'd1);
    bus.req_is_store = is_store;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    step();
    bus.req_valid    = 1'b0;
  endtask

  // Zero-wait load: bus fields in cycle 1, then done/write observed exactly in cycle 4.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_data, input int exp_we);
    int done_cnt = 0;
    int done_at  = 0;
    int we_cnt   = 0;
    int err_cnt  = 0;
    logic [31:0] wd = 32'd0;
    logic [31:0] wa = 32'd0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = rdata;
    applyStimulus(1'b0, f3, addr, 32'd0, rd);
    checkOutput({tag, "_mem_req_valid"}, {31'd0, bus.mem_req_valid}, 32'd1);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    checkOutput({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      if (bus.done) begin done_cnt++; done_at = i; end
      if (bus.err) err_cnt++;
      if (bus.write_ena) begin we_cnt++; wd = bus.write_data; wa = {27'd0, bus.regw_addr}; end
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    checkOutput({tag, "_done_cycle"}, done_at, 32'd4);
    checkOutput({tag, "_done_count"}, done_cnt, 32'd1);
    checkOutput({tag, "_err_count"}, err_cnt, 32'd0);
    checkOutput({tag, "_write_count"}, we_cnt, exp_we);
    if (exp_we != 0) begin
      checkOutput({tag, "_write_data"}, wd, exp_data);
      checkOutput({tag, "_regw_addr"}, wa, {27'd0, rd});
    end
  endtask

  // Rejected op: err in cycle 1, never a bus request, no write.
  task automatic runBad(input string tag, input logic is_store, input logic [2:0] f3,
                        input logic [31:0] addr);
    int err_at  = 0;
    int err_cnt = 0;
    int mreq    = 0;
    int others  = 0;
    bus.mem_req_ready = 1'b1;
    applyStimulus(is_store, f3, addr, 32'h1234_5678, 5'd9);
    for (int i = 1; i <= 5; i++) begin
      if (bus.err) begin err_cnt++; err_at = i; end
      if (bus.mem_req_valid) mreq++;
      if (bus.done || bus.write_ena) others++;
      step();
    end
    checkOutput({tag, "_err_cycle"}, err_at, 32'd1);
    checkOutput({tag, "_err_count"}, err_cnt, 32'd1);
    checkOutput({tag, "_no_bus"}, mreq, 32'd0);
    checkOutput({tag, "_no_done_write"}, others, 32'd0);
  endtask

  initial begin
    int err_at;
    int cnt_a;
    int cnt_b;
    bus.req_valid     = 1'b0;
    bus.req_is_store  = 1'b0;
    bus.req_funct3    = 3'd0;
    bus.req_addr      = 32'd0;
    bus.req_wdata     = 32'd0;
    bus.req_rd        = 5'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'd0;

    step();
    step();
    checkOutput("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("reset_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    checkOutput("reset_outputs", {bus.write_ena, bus.done, bus.err, bus.mem_we, bus.mem_wstrb},
                32'd0);
    rst = 1'b0;
    step();
    checkOutput("post_reset_req_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("[TB] LB sign-extended from lane 3");
    runLoad("lb", 3'd0, 32'h0000_1003, 32'h80FF_FF00, 5'd5, 32'hFFFF_FF80, 1);

    $display("[TB] SH upper half with one wait state");
    bus.mem_req_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 5'd0);
    checkOutput("sh_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    checkOutput("sh_mem_addr", bus.mem_addr, 32'h0000_2000);
    checkOutput("sh_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'hC);
    checkOutput("sh_mem_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_mem_we", {31'd0, bus.mem_we}, 32'd1);
    checkOutput("sh_req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
    step();
    checkOutput("sh_hold_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    checkOutput("sh_hold_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_hold_done", {31'd0, bus.done}, 32'd0);
    bus.mem_req_ready = 1'b1;
    step();
    checkOutput("sh_done", {31'd0, bus.done}, 32'd1);
    checkOutput("sh_write_ena", {31'd0, bus.write_ena}, 32'd0);
    checkOutput("sh_req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    step();
    checkOutput("sh_done_one_cycle", {31'd0, bus.done}, 32'd0);

    $display("[TB] SB zero-wait, done two cycles after acceptance");
    applyStimulus(1'b1, 3'd0, 32'h0000_3001, 32'h0000_00A5, 5'd0);
    checkOutput("sb_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h2);
    checkOutput("sb_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_done_early", {31'd0, bus.done}, 32'd0);
    step();
    checkOutput("sb_done", {31'd0, bus.done}, 32'd1);

    $display("[TB] SW full word");
    applyStimulus(1'b1, 3'd2, 32'h0000_3008, 32'hDEAD_BEEF, 5'd0);
    checkOutput("sw_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'hF);
    checkOutput("sw_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    step();
    checkOutput("sw_done", {31'd0, bus.done}, 32'd1);

    $display("[TB] LW to x0, LBU and LH");
    runLoad("lw_x0", 3'd2, 32'h0000_4000, 32'h1234_5678, 5'd0, 32'h1234_5678, 0);
    runLoad("lbu", 3'd4, 32'h0000_5002, 32'h00AB_0000, 5'd3, 32'h0000_00AB, 1);
    runLoad("lh", 3'd1, 32'h0000_5002, 32'h8001_1234, 5'd31, 32'hFFFF_8001, 1);
    runLoad("lhu", 3'd5, 32'h0000_5000, 32'h1234_F00D, 5'd4, 32'h0000_F00D, 1);

    $display("[TB] LHU timeout");
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    applyStimulus(1'b0, 3'd5, 32'h0000_6000, 32'd0, 5'd6);
    err_at = 0; cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 12; i++) begin
      if (bus.err) begin cnt_a++; err_at = i; end
      if (bus.done || bus.write_ena) cnt_b++;
      step();
    end
    checkOutput("timeout_err_cycle", err_at, 32'd7);
    checkOutput("timeout_err_count", cnt_a, 32'd1);
    checkOutput("timeout_no_done_write", cnt_b, 32'd0);
    checkOutput("timeout_req_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("[TB] illegal funct3");
    runBad("bad_load_f3", 1'b0, 3'd3, 32'h0000_7000);
    runBad("bad_store_f3", 1'b1, 3'd4, 32'h0000_7000);

    $display("[TB] misaligned LW");
`ifdef MISALIGN_TRAP_EN
    runBad("lw_misaligned", 1'b0, 3'd2, 32'h0000_1001);
`else
    runLoad("lw_misaligned", 3'd2, 32'h0000_1001, 32'hCAFE_F00D, 5'd7, 32'hCAFE_F00D, 1);
`endif

    $display("[TB] reset while waiting for a response");
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    applyStimulus(1'b0, 3'd2, 32'h0000_8000, 32'd0, 5'd8);
    step();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    checkOutput("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("abort_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h5555_AAAA;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.done || bus.write_ena || bus.err) cnt_a++;
    end
    bus.mem_rsp_valid = 1'b0;
    checkOutput("abort_no_activity", cnt_a, 32'd0);
    checkOutput("abort_idle_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
